// File: rtl/fft8_pkg.sv
// Shared constants, FSM state type and slot-index helper for the 8-point FFT frame loader.
package fft8_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int N              = 8;
    localparam int LOG2N          = 3;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // Reverses the three index bits so a natural-order stream lands in radix-2 DIT input order.
    function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

endpackage

// File: rtl/fft8_frame_loader.sv
// Collects 8 complex samples into a slot register file, then hands the frame to an FFT core.
// Define FFT8_LOADER_BITREV_EN to store sample cnt in slot bitrev3(cnt) instead of slot cnt.
module fft8_frame_loader #(
    parameter int DATA_W = fft8_pkg::DATA_W_DEFAULT,
    parameter int N      = fft8_pkg::N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_re,
    input  logic [DATA_W-1:0]     s_im,
    input  logic                  flush,
    output logic [DATA_W*N-1:0]   in_re_flat,
    output logic [DATA_W*N-1:0]   in_im_flat,
    output logic                  start,
    input  logic                  done,
    output logic                  busy
);
    import fft8_pkg::*;

    state_t             state;
    state_t             state_next;
    logic [LOG2N-1:0]   cnt;
    logic [LOG2N-1:0]   wr_idx;
    logic               accept;
    logic [DATA_W-1:0]  slot_re [N];
    logic [DATA_W-1:0]  slot_im [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // A flush cycle drops s_ready so the upstream never believes a discarded sample was taken.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        start      = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        case (state)
            FILL: begin
                s_ready = !rst && !flush;
                accept  = s_valid && s_ready;
                if (accept && (cnt == {LOG2N{1'b1}})) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                start      = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (done) begin
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

`ifdef FFT8_LOADER_BITREV_EN
    assign wr_idx = bitrev3(cnt);
`else
    assign wr_idx = cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == FILL) begin
            if (flush) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + LOG2N'(1);
            end
        end
    end

    // Slots change only on an accept, which keeps the frame frozen from LAUNCH until WAIT ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                slot_re[k] <= '0;
                slot_im[k] <= '0;
            end
        end else if (accept) begin
            slot_re[wr_idx] <= s_re;
            slot_im[wr_idx] <= s_im;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_flat
        assign in_re_flat[(k+1)*DATA_W-1 -: DATA_W] = slot_re[k];
        assign in_im_flat[(k+1)*DATA_W-1 -: DATA_W] = slot_im[k];
    end

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Randomized self-checking bench for fft8_frame_loader against a frame-level reference model.
// Build with FFT8_LOADER_BITREV_EN defined to exercise the bit-reversed slot order.
module tb_fft8_frame_loader;

    localparam int DW = 16;
    localparam int FLAT_W = DW * 8;

    localparam int M_FILL   = 0;
    localparam int M_LAUNCH = 1;
    localparam int M_WAIT   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DW-1:0]     s_re = '0;
    logic [DW-1:0]     s_im = '0;
    logic              flush = 1'b0;
    logic [FLAT_W-1:0] in_re_flat;
    logic [FLAT_W-1:0] in_im_flat;
    logic              start;
    logic              done = 1'b0;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase of the handshake, samples collected so far, expected slot contents.
    int            m_phase = M_FILL;
    int            m_count = 0;
    logic [DW-1:0] exp_re [8];
    logic [DW-1:0] exp_im [8];

    fft8_frame_loader #(.DATA_W(DW), .N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_re       (s_re),
        .s_im       (s_im),
        .flush      (flush),
        .in_re_flat (in_re_flat),
        .in_im_flat (in_im_flat),
        .start      (start),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Where the k-th sample of a frame is expected to land.
    function automatic int slot_of(input int k);
`ifdef FFT8_LOADER_BITREV_EN
        return ((k % 2) * 4) + (((k / 2) % 2) * 2) + (k / 4);
`else
        return k;
`endif
    endfunction

    function automatic logic [FLAT_W-1:0] pack_slots(input bit use_im);
        logic [FLAT_W-1:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[k*DW +: DW] = use_im ? exp_im[k] : exp_re[k];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_phase = M_FILL;
        m_count = 0;
        for (int k = 0; k < 8; k++) begin
            exp_re[k] = '0;
            exp_im[k] = '0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [FLAT_W-1:0] observed,
                               input logic [FLAT_W-1:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input logic fl);
        checkOutput("start", FLAT_W'(start), FLAT_W'(m_phase == M_LAUNCH));
        checkOutput("busy", FLAT_W'(busy), FLAT_W'(m_phase == M_WAIT));
        if (!fl) begin
            checkOutput("s_ready", FLAT_W'(s_ready), FLAT_W'(m_phase == M_FILL));
        end
        checkOutput("in_re_flat", in_re_flat, pack_slots(1'b0));
        checkOutput("in_im_flat", in_im_flat, pack_slots(1'b1));
    endtask

    // One clock cycle: drive inputs, check outputs on the falling edge, advance the model on the rising edge.
    task automatic applyStimulus(input logic v, input int re, input int im,
                                 input logic fl, input logic dn);
        s_valid = v;
        s_re    = re[DW-1:0];
        s_im    = im[DW-1:0];
        flush   = fl;
        done    = dn;
        @(negedge clk);
        check_all(fl);
        @(posedge clk);
        case (m_phase)
            M_FILL: begin
                if (fl) begin
                    m_count = 0;
                end else if (v) begin
                    exp_re[slot_of(m_count)] = re[DW-1:0];
                    exp_im[slot_of(m_count)] = im[DW-1:0];
                    m_count++;
                    if (m_count == 8) begin
                        m_count = 0;
                        m_phase = M_LAUNCH;
                    end
                end
            end
            M_LAUNCH: m_phase = M_WAIT;
            default: if (dn) m_phase = M_FILL;
        endcase
        #1;
    endtask

    // Reset asserted between clock edges: outputs must clear with no edge in between.
    task automatic doAsyncReset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checkOutput({tag, "_s_ready"}, FLAT_W'(s_ready), '0);
        checkOutput({tag, "_start"}, FLAT_W'(start), '0);
        checkOutput({tag, "_busy"}, FLAT_W'(busy), '0);
        checkOutput({tag, "_re_flat"}, in_re_flat, '0);
        checkOutput({tag, "_im_flat"}, in_im_flat, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int cosv[8];
        cosv = '{32767, 23170, 0, -23170, -32767, -23170, 0, 23170};
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_s_ready", FLAT_W'(s_ready), '0);
        checkOutput("reset_start", FLAT_W'(start), '0);
        checkOutput("reset_busy", FLAT_W'(busy), '0);
        checkOutput("reset_re_flat", in_re_flat, '0);
        rst = 1'b0;

        // Cosine frame with s_valid held high into LAUNCH and a 20-cycle WAIT.
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, cosv[k], int'($urandom), 1'b0, 1'b0);
        for (int k = 0; k < 21; k++) applyStimulus(1'b1, int'($urandom), int'($urandom), 1'b0, 1'b0);
`ifndef FFT8_LOADER_BITREV_EN
        checkOutput("cos_slot0", FLAT_W'(in_re_flat[15:0]), FLAT_W'(16'h7fff));
        checkOutput("cos_slot2", FLAT_W'(in_re_flat[47:32]), '0);
        checkOutput("cos_slot4", FLAT_W'(in_re_flat[79:64]), FLAT_W'(16'h8001));
`endif
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);

        // Samples 1..8, with done raised during FILL where it has no effect.
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, k + 1, 1000 + k, 1'b0, k[0]);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
`ifndef FFT8_LOADER_BITREV_EN
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("seq_slot%0d", k), FLAT_W'(in_re_flat[k*DW +: DW]), FLAT_W'(k + 1));
        end
`endif
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);

        // Partial frame discarded by flush, then 100..107.
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, int'($urandom), int'($urandom), 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 100 + k, 200 + k, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
`ifndef FFT8_LOADER_BITREV_EN
        checkOutput("flush_slot7", FLAT_W'(in_re_flat[127:112]), FLAT_W'(107));
`endif
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);

        // Reset mid-frame, then again while waiting on the core.
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, int'($urandom), int'($urandom), 1'b0, 1'b0);
        doAsyncReset("rst_fill");
        for (int k = 0; k < 12; k++) applyStimulus(1'b1, int'($urandom), int'($urandom), 1'b0, 1'b0);
        doAsyncReset("rst_wait");
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);

`ifdef FFT8_LOADER_BITREV_EN
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, k, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        checkOutput("bitrev_slot1", FLAT_W'(in_re_flat[31:16]), FLAT_W'(4));
        checkOutput("bitrev_slot3", FLAT_W'(in_re_flat[63:48]), FLAT_W'(6));
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
`endif

        // Random traffic with sporadic flush and done.
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom % 4) != 0, int'($urandom), int'($urandom),
                          ($urandom % 16) == 0, ($urandom % 6) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft8_frame_loader.md
FFT8_FRAME_LOADER -- requirements
Module: fft8_frame_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed two's-complement Q1.15 sample width.
REQ-002 SHALL have parameter N, default 8, frame length; only 8 supported.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_valid  input  1  input sample valid.
REQ-006 SHALL have port s_ready  output  1  loader accepts a sample this cycle.
REQ-007 SHALL have port s_re  input  DATA_W  sample real part, signed.
REQ-008 SHALL have port s_im  input  DATA_W  sample imaginary part, signed.
REQ-009 SHALL have port flush  input  1  discard a partially collected frame.
REQ-010 SHALL have port in_re_flat  output  DATA_W*8  packed real parts to the FFT core; slot k at bits [(k+1)*DATA_W-1 -: DATA_W].
REQ-011 SHALL have port in_im_flat  output  DATA_W*8  packed imaginary parts, same layout.
REQ-012 SHALL have port start  output  1  single-cycle FFT start pulse.
REQ-013 SHALL have port done  input  1  FFT core completion, from core.
REQ-014 SHALL have port busy  output  1  frame handed off and not yet completed.

Function
REQ-015 SHALL implement states FILL, LAUNCH, WAIT; a sample is accepted when s_valid and s_ready are both high.
REQ-016 FILL: s_ready=1, 3-bit index cnt; each accept writes the sample into slot cnt and increments cnt.
REQ-017 Accept with cnt=7: cnt wraps to 0 and the next state is LAUNCH.
REQ-018 LAUNCH: lasts exactly one cycle with start=1 and s_ready=0, then goes to WAIT; latency is 8th accept at edge t, start high during cycle t..t+1.
REQ-019 WAIT: busy=1, s_ready=0; on done=1, go to FILL so that s_ready=1 on the following cycle.
REQ-020 done SHALL be ignored in FILL and LAUNCH.
REQ-021 in_re_flat/in_im_flat SHALL be stable from LAUNCH until the cycle after done is seen in WAIT; slots are overwritten only by FILL accepts.
REQ-022 flush in FILL SHALL zero cnt, accept no sample that cycle, and leave the slot contents unchanged.
REQ-023 flush SHALL be ignored in LAUNCH and WAIT.
REQ-024 SHALL perform no arithmetic on samples; stored bit-exact.

Reset
REQ-025 rst high SHALL force the following, asynchronously, including mid-frame or in WAIT: state=FILL, cnt=0, start=0, busy=0, s_ready=0 while rst is asserted, and both flat buses all-zero.
REQ-026 After rst deasserts, s_ready SHALL be 1 from the first clock edge onward.

Configuration
REQ-027 With FFT8_LOADER_BITREV_EN defined, the sample accepted at index cnt SHALL be written to slot bitrev3(cnt), giving the mapping 0,4,2,6,1,5,3,7.
REQ-028 Without FFT8_LOADER_BITREV_EN, sample cnt SHALL be written to slot cnt (natural order).

Structure
REQ-029 Package fft8_pkg SHALL hold the following:
- DATA_W default
- N=8
- LOG2N=3
- the state enum
- the bitrev3 function
REQ-030 SHALL be a single module with no sub-module; the slot register file is inline.

Verification
REQ-031 Natural order, stream x[k]=round(32767*cos(2*pi*k/8)) with s_valid held high: slot0=32767, slot2=0, slot4=-32767; start pulses for exactly 1 cycle, the cycle after the 8th accept.
REQ-032 done held low 20 cycles after start: s_ready=0, busy=1, flat buses unchanged; s_valid held high is not accepted.
REQ-033 done pulse in WAIT: s_ready=1 the next cycle; the next 8 samples 1..8 give slot k = k+1.
REQ-034 Three samples then flush, then 8 samples 100..107: slot k=100+k; only one start.
REQ-035 rst pulsed after 5 samples and again in WAIT: all outputs reach their reset values immediately; no start until 8 new accepts.
REQ-036 With FFT8_LOADER_BITREV_EN defined, inputs 0..7 give slots {0,4,2,6,1,5,3,7}, i.e. slot1=4 and slot3=6.
